// File: rtl/dut_req_sched.sv
// dut_req_sched: round-robin scheduler sharing the boolean-gate dut's
// write/read method ports among NREQ operand requesters.
// Per grant: write A (addr 4), write B (addr 5), read Y (addr 3), then
// present the result tagged with the requester index.
// Ports: CLK, RST (async, active-high);
//   requester side: req_valid/req_a/req_b in, req_ready out (one-hot);
//   consumer side: rsp_valid/rsp_data/rsp_id/rsp_err out, rsp_ready in;
//   dut side: write_address/write_data/write_en out, write_rdy in,
//     read_address/read_en out, read_data/read_rdy in;
//   busy out: a transaction is in flight.
// Optional macro SCHED_TIMEOUT_EN: abort a handshake that waits TIMEOUT
// cycles and return rsp_err=1 with rsp_data=0.
module dut_req_sched #(
  parameter int NREQ    = 2,
  parameter int IDW     = 3,
  parameter int TIMEOUT = 15
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_a,
  input  logic [NREQ-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  output logic            rsp_valid,
  output logic            rsp_data,
  output logic [IDW-1:0]  rsp_id,
  output logic            rsp_err,
  input  logic            rsp_ready,
  output logic [2:0]      write_address,
  output logic            write_data,
  output logic            write_en,
  input  logic            write_rdy,
  output logic [2:0]      read_address,
  output logic            read_en,
  input  logic            read_data,
  input  logic            read_rdy,
  output logic            busy
);

  localparam logic [2:0] ADDR_A = 3'd4;
  localparam logic [2:0] ADDR_B = 3'd5;
  localparam logic [2:0] ADDR_Y = 3'd3;

  if (NREQ < 2 || NREQ > 8 || IDW < 1 ||
      (1 << IDW) < NREQ || TIMEOUT < 1) begin : g_cfg_chk
    $error("dut_req_sched: unsupported parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_RD_Y,
    S_RSP
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic           a_q, a_d;
  logic           b_q, b_d;
  logic           y_q, y_d;

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gid;
  logic [IDW-1:0]  gnext;
  logic            any;
  int              off;
  int              sum;

  // Rotate the request vector so ptr sits at bit 0; the first set bit
  // is then the round-robin winner, offset from ptr.
  always_comb begin
    rot = NREQ'({req_valid, req_valid} >> ptr_q);
    any = 1'b0;
    off = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        off = k;
      end
    end
    sum = int'(ptr_q) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    gid   = IDW'(sum);
    gnext = (sum == NREQ - 1) ? '0 : IDW'(sum + 1);
    gnt   = any ? (NREQ'(1) << gid) : '0;
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int CW =
    ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          stall;
`endif

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    a_d           = a_q;
    b_d           = b_q;
    y_d           = y_q;
    req_ready     = '0;
    rsp_valid     = 1'b0;
    write_address = '0;
    write_data    = 1'b0;
    write_en      = 1'b0;
    read_address  = '0;
    read_en       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Reset holds state in IDLE, so gate the strobe explicitly.
        req_ready = RST ? '0 : gnt;
        if (any) begin
          state_d = S_WR_A;
          ptr_d   = gnext;
          id_d    = gid;
          a_d     = |(req_a & gnt);
          b_d     = |(req_b & gnt);
        end
      end
      S_WR_A: begin
        write_address = ADDR_A;
        write_data    = a_q;
        write_en      = write_rdy;
        if (write_rdy) state_d = S_WR_B;
      end
      S_WR_B: begin
        write_address = ADDR_B;
        write_data    = b_q;
        write_en      = write_rdy;
        if (write_rdy) state_d = S_RD_Y;
      end
      S_RD_Y: begin
        read_address = ADDR_Y;
        read_en      = read_rdy;
        if (read_rdy) begin
          y_d     = read_data;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SCHED_TIMEOUT_EN
    err_d = err_q;
    cnt_d = cnt_q;
    stall = (state_q == S_WR_A || state_q == S_WR_B ||
             state_q == S_RD_Y) && !(write_en || read_en);
    if (state_q == S_RSP && rsp_ready) err_d = 1'b0;
    if (stall && cnt_q == CW'(TIMEOUT - 1)) begin
      state_d = S_RSP;
      err_d   = 1'b1;
      y_d     = 1'b0;
    end
    // Every state change restarts the wait window.
    if (state_d != state_q) cnt_d = '0;
    else if (stall) cnt_d = cnt_q + CW'(1);
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_data = y_q;
  assign rsp_id   = id_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dut_req_sched.sv
// tb_dut_req_sched: randomized self-checking bench for dut_req_sched
// with an OR-gate dut model on the write/read method ports.
module tb_dut_req_sched;

  localparam int NREQ    = 2;
  localparam int IDW     = 3;
  localparam int TIMEOUT = 15;

  logic            CLK = 1'b0;
  logic            RST;
  logic [NREQ-1:0] req_valid, req_a, req_b, req_ready;
  logic            rsp_valid, rsp_data, rsp_err, rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [2:0]      write_address, read_address;
  logic            write_data, write_en, write_rdy;
  logic            read_en, read_data, read_rdy, busy;

  int n_chk = 0;
  int n_pass = 0;
  int mptr = 0;

  always #5 CLK = ~CLK;

  // OR-gate dut: last written A and B, Y = A | B.
  logic ma = 1'b0;
  logic mb = 1'b0;
  always @(posedge CLK) begin
    if (write_en && write_address == 3'd4) ma <= write_data;
    if (write_en && write_address == 3'd5) mb <= write_data;
  end
  assign read_data = ma | mb;

  dut_req_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) u_dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .write_address(write_address), .write_data(write_data),
    .write_en(write_en), .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en),
    .read_data(read_data), .read_rdy(read_rdy),
    .busy(busy)
  );

  // Reference arbiter: first pending requester at or after p, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic test_reset();
    req_valid = '1;
    repeat (2) @(negedge CLK);
    #1;
    n_chk++;
    if ({req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, write_address,
         write_data, write_en, read_address, read_en, busy} !== '0)
      $display("FAIL reset_outputs got=%b req_ready=%b busy=%b", 
               {rsp_valid, write_en, read_en}, req_ready, busy);
    else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
    req_valid = '0;
    mptr = 0;
  endtask

  task automatic test_basic();
    @(negedge CLK);
    req_valid = 2'b01; req_a = 2'b01; req_b = 2'b00;
    #1;
    n_chk++;
    if ({req_ready, busy} !== 3'b010)
      $display("FAIL basic_grant got=%b exp=010", {req_ready, busy});
    else n_pass++;
    mptr = 1;
    @(negedge CLK); req_valid = '0; #1;
    n_chk++;
    if ({write_en, write_address, write_data, read_en, read_address}
        !== 9'b1_100_1_0_000)
      $display("FAIL basic_wr_a got=%b exp=110010000",
               {write_en, write_address, write_data, read_en, read_address});
    else n_pass++;
    @(negedge CLK); #1;
    n_chk++;
    if ({write_en, write_address, write_data, read_en, read_address}
        !== 9'b1_101_0_0_000)
      $display("FAIL basic_wr_b got=%b exp=110100000",
               {write_en, write_address, write_data, read_en, read_address});
    else n_pass++;
    @(negedge CLK); #1;
    n_chk++;
    if ({write_en, write_address, read_en, read_address} !== 8'b0_000_1_011)
      $display("FAIL basic_rd_y got=%b exp=00001011",
               {write_en, write_address, read_en, read_address});
    else n_pass++;
    @(negedge CLK); #1;
    n_chk++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_err, busy} !== 7'b1_1_000_0_1)
      $display("FAIL basic_rsp got=%b exp=1100001",
               {rsp_valid, rsp_data, rsp_id, rsp_err, busy});
    else n_pass++;
    @(negedge CLK); #1;
    n_chk++;
    if ({rsp_valid, busy} !== 2'b00)
      $display("FAIL basic_idle got=%b exp=00", {rsp_valid, busy});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    req_a = NREQ'($urandom); req_b = NREQ'($urandom);
    for (int t = 0; t < 6; t++) begin
      int g;
      logic ey;
      logic [NREQ-1:0] er;
      @(negedge CLK);
      req_valid = '1;
      #1;
      g = rr_pick(req_valid, mptr);
      er = '0; er[g] = 1'b1;
      ey = req_a[g] | req_b[g];
      n_chk++;
      if (req_ready !== er)
        $display("FAIL b2b_grant t=%0d got=%b exp=%b", t, req_ready, er);
      else n_pass++;
      mptr = (g + 1) % NREQ;
      for (int c = 1; c < 4; c++) begin
        @(negedge CLK);
        if (c == 1) begin
          req_a[g] = 1'($urandom); req_b[g] = 1'($urandom);
        end
        #1;
        n_chk++;
        if ({req_ready, busy} !== {NREQ'(0), 1'b1})
          $display("FAIL b2b_busy c=%0d got=%b exp=%b", c,
                   {req_ready, busy}, {NREQ'(0), 1'b1});
        else n_pass++;
      end
      @(negedge CLK); #1;
      n_chk++;
      if ({rsp_valid, rsp_data, rsp_id, rsp_err} !==
          {1'b1, ey, IDW'(g), 1'b0})
        $display("FAIL b2b_rsp t=%0d got=%b exp=%b", t,
                 {rsp_valid, rsp_data, rsp_id, rsp_err},
                 {1'b1, ey, IDW'(g), 1'b0});
      else n_pass++;
    end
  endtask

  task automatic test_rsp_hold();
    int g;
    logic ey;
    logic [NREQ-1:0] er;
    @(negedge CLK);
    rsp_ready = 1'b0; req_valid = '1;
    req_a = NREQ'($urandom); req_b = NREQ'($urandom);
    #1;
    g = rr_pick(req_valid, mptr);
    er = '0; er[g] = 1'b1;
    ey = req_a[g] | req_b[g];
    n_chk++;
    if (req_ready !== er)
      $display("FAIL hold_grant got=%b exp=%b", req_ready, er);
    else n_pass++;
    mptr = (g + 1) % NREQ;
    repeat (3) @(negedge CLK);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (c == 3) rsp_ready = 1'b1;
      #1;
      n_chk++;
      if ({rsp_valid, rsp_data, rsp_id, rsp_err, busy, req_ready} !==
          {1'b1, ey, IDW'(g), 1'b0, 1'b1, NREQ'(0)})
        $display("FAIL hold_stable c=%0d got=%b exp=%b", c,
                 {rsp_valid, rsp_data, rsp_id, rsp_err, busy, req_ready},
                 {1'b1, ey, IDW'(g), 1'b0, 1'b1, NREQ'(0)});
      else n_pass++;
    end
    @(negedge CLK); #1;
    g = rr_pick(req_valid, mptr);
    er = '0; er[g] = 1'b1;
    ey = req_a[g] | req_b[g];
    n_chk++;
    if ({req_ready, busy} !== {er, 1'b0})
      $display("FAIL hold_regrant got=%b exp=%b", {req_ready, busy},
               {er, 1'b0});
    else n_pass++;
    mptr = (g + 1) % NREQ;
    @(negedge CLK); req_valid = '0;
    repeat (2) @(negedge CLK);
    @(negedge CLK); #1;
    n_chk++;
    if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, ey, IDW'(g)})
      $display("FAIL hold_rsp2 got=%b exp=%b", {rsp_valid, rsp_data, rsp_id},
               {1'b1, ey, IDW'(g)});
    else n_pass++;
  endtask

  task automatic test_wr_stall();
    int g;
    logic ey;
    logic [NREQ-1:0] er;
    @(negedge CLK);
    req_valid = '0;
    req_valid[$urandom_range(0, NREQ - 1)] = 1'b1;
    req_a = NREQ'($urandom); req_b = NREQ'($urandom);
    #1;
    g = rr_pick(req_valid, mptr);
    er = '0; er[g] = 1'b1;
    ey = req_a[g] | req_b[g];
    n_chk++;
    if (req_ready !== er)
      $display("FAIL stall_grant got=%b exp=%b", req_ready, er);
    else n_pass++;
    mptr = (g + 1) % NREQ;
    @(negedge CLK); req_valid = '0;
    for (int s = 0; s < 4; s++) begin
      @(negedge CLK); write_rdy = 1'b0; #1;
      n_chk++;
      if ({write_en, write_address, read_en, rsp_valid} !== 6'b0_101_0_0)
        $display("FAIL stall_hold s=%0d got=%b exp=010100", s,
                 {write_en, write_address, read_en, rsp_valid});
      else n_pass++;
    end
    @(negedge CLK); write_rdy = 1'b1; #1;
    n_chk++;
    if ({write_en, write_address, write_data} !== {4'b1_101, req_b[g]})
      $display("FAIL stall_wr_b got=%b exp=%b",
               {write_en, write_address, write_data}, {4'b1_101, req_b[g]});
    else n_pass++;
    @(negedge CLK); #1;
    @(negedge CLK); #1;
    n_chk++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, ey, IDW'(g), 1'b0})
      $display("FAIL stall_rsp got=%b exp=%b",
               {rsp_valid, rsp_data, rsp_id, rsp_err},
               {1'b1, ey, IDW'(g), 1'b0});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic ey;
    @(negedge CLK);
    req_valid = 2'b01;
    req_a = NREQ'($urandom); req_b = NREQ'($urandom);
    #1;
    n_chk++;
    if (req_ready !== 2'b01)
      $display("FAIL rmid_grant got=%b exp=01", req_ready);
    else n_pass++;
    mptr = 1;
    @(negedge CLK); req_valid = '0;
    @(negedge CLK);
    @(negedge CLK); read_rdy = 1'b0; #1;
    n_chk++;
    if ({read_address, read_en, busy} !== 5'b011_0_1)
      $display("FAIL rmid_in_rd got=%b exp=01101",
               {read_address, read_en, busy});
    else n_pass++;
    #2;
    RST = 1'b1; req_valid = '1;
    #1;
    n_chk++;
    if ({req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, write_address,
         write_data, write_en, read_address, read_en, busy} !== '0)
      $display("FAIL rmid_async got req_ready=%b busy=%b rsp_valid=%b",
               req_ready, busy, rsp_valid);
    else n_pass++;
    mptr = 0;
    @(negedge CLK);
    RST = 1'b0; read_rdy = 1'b1;
    #1;
    ey = req_a[0] | req_b[0];
    n_chk++;
    if (req_ready !== 2'b01)
      $display("FAIL rmid_ptr_reset got=%b exp=01", req_ready);
    else n_pass++;
    mptr = 1;
    @(negedge CLK); req_valid = '0;
    repeat (2) @(negedge CLK);
    @(negedge CLK); #1;
    n_chk++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, ey, 4'b0000})
      $display("FAIL rmid_rsp got=%b exp=%b",
               {rsp_valid, rsp_data, rsp_id, rsp_err}, {1'b1, ey, 4'b0000});
    else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int g, ph, budget;
      logic ey, ea, eb, wr, rd, rr;
      logic [NREQ-1:0] er;
      logic [7:0] ebus;
      @(negedge CLK);
      req_valid = NREQ'($urandom);
      write_rdy = 1'($urandom); read_rdy = 1'($urandom);
      rsp_ready = 1'($urandom);
      #1;
      g = rr_pick(req_valid, mptr);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      n_chk++;
      if ({req_ready, busy} !== {er, 1'b0})
        $display("FAIL rand_grant t=%0d got=%b exp=%b", t,
                 {req_ready, busy}, {er, 1'b0});
      else n_pass++;
      if (g >= 0) begin
        mptr = (g + 1) % NREQ;
        ea = req_a[g]; eb = req_b[g]; ey = ea | eb;
        ph = 0; budget = 100;
        while (ph < 4 && budget > 0) begin
          @(negedge CLK);
          if (budget == 100) begin
            req_a[g] = 1'($urandom); req_b[g] = 1'($urandom);
          end
          req_valid = NREQ'($urandom);
          wr = ($urandom_range(0, 3) != 0);
          rd = ($urandom_range(0, 3) != 0);
          rr = 1'($urandom);
          write_rdy = wr; read_rdy = rd; rsp_ready = rr;
          #1;
          case (ph)
            0: ebus = {wr, 3'd4, 1'b0, 3'd0};
            1: ebus = {wr, 3'd5, 1'b0, 3'd0};
            2: ebus = {1'b0, 3'd0, rd, 3'd3};
            default: ebus = 8'd0;
          endcase
          n_chk++;
          if ({write_en, write_address, read_en, read_address, req_ready,
               busy, rsp_valid} !== {ebus, NREQ'(0), 1'b1, ph == 3})
            $display("FAIL rand_bus t=%0d ph=%0d got=%b exp=%b", t, ph,
                     {write_en, write_address, read_en, read_address,
                      req_ready, busy, rsp_valid},
                     {ebus, NREQ'(0), 1'b1, ph == 3});
          else n_pass++;
          if (ph < 2) begin
            n_chk++;
            if (write_data !== (ph == 0 ? ea : eb))
              $display("FAIL rand_wdata t=%0d ph=%0d got=%b exp=%b", t, ph,
                       write_data, (ph == 0 ? ea : eb));
            else n_pass++;
          end
          if (ph == 3) begin
            n_chk++;
            if ({rsp_data, rsp_id, rsp_err} !== {ey, IDW'(g), 1'b0})
              $display("FAIL rand_rsp t=%0d got=%b exp=%b", t,
                       {rsp_data, rsp_id, rsp_err}, {ey, IDW'(g), 1'b0});
            else n_pass++;
          end
          if ((ph < 2 && wr) || (ph == 2 && rd) || (ph == 3 && rr))
            ph++;
          budget--;
        end
        if (ph < 4) begin
          n_chk++;
          $display("FAIL rand_hang t=%0d stuck in phase %0d exp done", t, ph);
        end
      end
    end
    @(negedge CLK);
    req_valid = '0; rsp_ready = 1'b1; write_rdy = 1'b1; read_rdy = 1'b1;
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge CLK);
    req_valid = 2'b01; req_a[0] = 1'b1; req_b[0] = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 2'b01)
      $display("FAIL to_grant got=%b exp=01", req_ready);
    else n_pass++;
    mptr = 1;
    @(negedge CLK); req_valid = '0;
    @(negedge CLK);
    for (int c = 3; c < 18; c++) begin
      @(negedge CLK);
      if (c == 3) read_rdy = 1'b0;
      #1;
      n_chk++;
      if ({rsp_valid, read_en, busy} !== 3'b001)
        $display("FAIL to_wait c=%0d got=%b exp=001", c,
                 {rsp_valid, read_en, busy});
      else n_pass++;
    end
    @(negedge CLK); #1;
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_data} !== 3'b110)
      $display("FAIL to_abort got=%b exp=110", {rsp_valid, rsp_err, rsp_data});
    else n_pass++;
    @(negedge CLK);
    read_rdy = 1'b1; req_valid = 2'b01; req_a[0] = 1'b1; req_b[0] = 1'b0;
    #1;
    n_chk++;
    if ({req_ready, busy} !== 3'b010)
      $display("FAIL to_regrant got=%b exp=010", {req_ready, busy});
    else n_pass++;
    mptr = 1;
    @(negedge CLK); req_valid = '0;
    repeat (2) @(negedge CLK);
    @(negedge CLK); #1;
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_data} !== 3'b101)
      $display("FAIL to_recover got=%b exp=101",
               {rsp_valid, rsp_err, rsp_data});
    else n_pass++;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog expired exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1; write_rdy = 1'b1; read_rdy = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_rsp_hold();
    test_wr_stall();
    test_reset_mid();
    test_random();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dut_req_sched.md
# dut_req_sched

Round-robin scheduler that shares the single write/read method interface of the boolean-gate `dut` among `NREQ` operand requesters. Per granted request it writes operand A, writes operand B, reads result Y, and returns the result tagged with the requester index. It sits between requester-side logic and `dut`, replacing direct bench drive of the `write_*`/`read_*` ports.

## Interface
- `NREQ`, 2: number of requesters; 2..8.
- `IDW`, 3: width of `rsp_id`; must be at least clog2(`NREQ`), minimum 1.
- `TIMEOUT`, 15: maximum wait cycles per DUT handshake before abort; only used with `SCHED_TIMEOUT_EN`.

- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_a` in NREQ: operand A bit, one per requester.
- `req_b` in NREQ: operand B bit, one per requester.
- `req_ready` out NREQ: one-hot accept strobe.
- `rsp_valid` out 1: result available.
- `rsp_data` out 1: Y value.
- `rsp_id` out IDW: index of the requester that owns the result.
- `rsp_err` out 1: result aborted by timeout.
- `rsp_ready` in 1: consumer accepts the result.
- `write_address` out 3, `write_data` out 1, `write_en` out 1: DUT write method.
- `write_rdy` in 1: DUT write method ready.
- `read_address` out 3, `read_en` out 1: DUT read method.
- `read_data` in 1, `read_rdy` in 1: DUT read value and ready.
- `busy` out 1: state is not IDLE.

## Operation
- DUT address map: A FIFO = 4, B FIFO = 5, Y FIFO = 3. `write_address` and `read_address` are driven to these constants only in the matching state and are 0 otherwise.
- FSM states: IDLE → WR_A → WR_B → RD_Y → RSP → IDLE.
- IDLE: round-robin grant among the asserted `req_valid` bits, searching from `ptr` upward with wrap. Assert `req_ready[g]` combinationally, latch `req_a[g]`, `req_b[g]` and `g`, set `ptr` = (g+1) mod NREQ, and go to WR_A. If no request is pending, stay in IDLE.
- WR_A: `write_en` = `write_rdy`, `write_data` = latched A. The state advances on the edge where `write_en` is high.
- WR_B: same as WR_A, using the latched B.
- RD_Y: `read_en` = `read_rdy`. `read_data` is captured on the same edge and the FSM goes to RSP.
- RSP: `rsp_valid` = 1; `rsp_data`, `rsp_id` and `rsp_err` stay stable until `rsp_ready`, then the FSM returns to IDLE.
- `write_en` and `read_en` are never asserted while the matching `*_rdy` is low, and are never asserted together.
- Only one transaction is in flight; no request is accepted outside IDLE.
- Requester priority: `ptr` resets to 0, so requester 0 has the highest priority after reset.

## Timing
- Reset values: every output 0 (`req_ready`, `rsp_*`, `write_*`, `read_*`, `busy`); state IDLE; `ptr` 0; latched operands 0.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and the in-flight request is dropped. `dut` is not reset by this block; residual A/B FIFO contents are the environment's responsibility.
- Best-case latency from accept edge (cycle 0) with all `*_rdy` high: WR_A at cycle 1, WR_B at cycle 2, RD_Y at cycle 3, `rsp_valid` at cycle 4.
- Each `*_rdy` low cycle adds one cycle of latency.
- `rsp_ready` high in the first RSP cycle allows a new grant in the next cycle, so back-to-back throughput is one result per 5 cycles.
- `req_valid` dropped before grant: no effect. Requesters hold `req_valid`, `req_a` and `req_b` until they see `req_ready`.
- `rsp_ready` held high outside RSP: ignored.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - A 4-bit-or-wider wait counter clears on every state entry and increments each cycle spent in WR_A, WR_B or RD_Y without a handshake.
  - When the counter reaches `TIMEOUT`, the FSM goes to RSP with `rsp_err` = 1 and `rsp_data` = 0.
  - `rsp_err` clears when the RSP handshake completes.
- `SCHED_TIMEOUT_EN` undefined: no counter, `rsp_err` tied to 0, and the FSM waits indefinitely on `*_rdy`.

## Test plan
- Reset, then requester 0 with A=1, B=0 on the OR `dut`, all ready high → `write_en` at cycles 1–2 (address 4 then 5), `read_en` at cycle 3 (address 3), `rsp_valid` at cycle 4 with `rsp_data`=1 and `rsp_id`=0.
- Both requesters valid continuously with `rsp_ready`=1 → grants alternate 0, 1, 0, 1; each `rsp_id` matches its grant; results 5 cycles apart.
- `rsp_ready` held low for 3 cycles in RSP → outputs stable and no new `req_ready`; grant occurs the cycle after `rsp_ready` rises.
- Force `write_rdy` low for 4 cycles during WR_B → `write_en` stays 0 during the stall; the response arrives 4 cycles late with the correct value.
- `RST` pulsed while in RD_Y → all outputs 0 asynchronously, `busy`=0, `ptr`=0; after release, requester 0 wins when both requesters are valid.
- With `SCHED_TIMEOUT_EN` and `TIMEOUT`=15, hold `read_rdy` low → RSP is entered 15 cycles after RD_Y entry with `rsp_err`=1 and `rsp_data`=0, and the next transaction completes normally with `rsp_err`=0.
